// File: rtl/bcd_pkg.sv
// ---- bcd_pkg: shared constants and state encoding for the BCD converter ----
// ---- Revision 1.0 ----
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGITS = 10;
  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_OVF   = 4'hF;
  localparam int         POS_MAX    = 9999;
  localparam int         NEG_MAX    = 999;

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ---- bcd_add3: double-dabble digit corrector, adds 3 to digits of 5 or more ----
// ---- Revision 1.0 ----
`default_nettype none

module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/reg_bcd_converter.sv
// ---- reg_bcd_converter: sequential 32-bit binary to 4-digit BCD display formatter ----
// ---- Revision 1.0 ----
`default_nettype none

module reg_bcd_converter
  import bcd_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  output logic [15:0] digits_o,
  output logic        neg_o,
  output logic        ovf_o,
  output logic        valid_o,
  output logic        busy_o
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_src;
  logic [31:0] r_mag;
  logic [39:0] r_bcd;
  logic [4:0]  r_cnt;
  logic        r_neg;

  logic [39:0] w_adj;
  logic        w_trigger;
  logic        w_neg_in;
  logic [31:0] w_src_mag;
  logic        w_fit;
  logic [15:0] w_fmt_digits;
  logic        w_fmt_ovf;

  assign w_trigger = !valid_o || (data_i != r_src);
  assign w_neg_in  = SIGNED_IN ? data_i[31] : 1'b0;
  assign busy_o    = (r_state != IDLE);

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .i_digit (r_bcd[4*gi +: 4]),
        .o_digit (w_adj[4*gi +: 4])
      );
    end
  endgenerate

  // r_src is frozen for the whole conversion, so it yields the range check directly.
  assign w_src_mag = r_neg ? (~r_src + 32'd1) : r_src;
  assign w_fit     = r_neg ? (w_src_mag <= 32'(NEG_MAX)) : (w_src_mag <= 32'(POS_MAX));

  always_comb begin
    w_fmt_digits = {4{CODE_OVF}};
    w_fmt_ovf    = 1'b1;
    if (w_fit) begin
      w_fmt_ovf    = 1'b0;
      w_fmt_digits = r_neg ? {CODE_MINUS, r_bcd[11:0]} : r_bcd[15:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_next = SHIFT;
      SHIFT:   if (r_cnt == 5'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src    <= '0;
      r_mag    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      digits_o <= '0;
      neg_o    <= 1'b0;
      ovf_o    <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_src <= data_i;
            r_neg <= w_neg_in;
            r_mag <= w_neg_in ? (~data_i + 32'd1) : data_i;
            r_bcd <= '0;
            r_cnt <= 5'd31;
          end
        end
        SHIFT: begin
          {r_bcd, r_mag} <= {w_adj[38:0], r_mag, 1'b0};
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        DONE: begin
          digits_o <= w_fmt_digits;
          neg_o    <= r_neg;
          ovf_o    <= w_fmt_ovf;
          valid_o  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_bcd_converter.sv
// ---- tb_reg_bcd_converter: scoreboard bench for signed and unsigned converter instances ----
// ---- Revision 1.0 ----
`default_nettype none

module tb_reg_bcd_converter;

  typedef struct packed {
    logic [15:0] d;
    logic        n;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_s, data_u;
  logic [15:0] dig_s, dig_u;
  logic        neg_s, neg_u, ovf_s, ovf_u, val_s, val_u, busy_s, busy_u;

  exp_t q_s[$];
  exp_t q_u[$];
  exp_t e_s, e_u;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_s  = 0;
  int   done_u  = 0;
  logic prev_s = 1'b0, prev_u = 1'b0, glitch_s = 1'b0, glitch_u = 1'b0;
  logic [18:0] hold_s = '0, hold_u = '0;

  always #5 clk = ~clk;

  reg_bcd_converter #(.SIGNED_IN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .data_i(data_s), .digits_o(dig_s),
    .neg_o(neg_s), .ovf_o(ovf_s), .valid_o(val_s), .busy_o(busy_s)
  );

  reg_bcd_converter #(.SIGNED_IN(1'b0)) dut_u (
    .clk(clk), .rst(rst), .data_i(data_u), .digits_o(dig_u),
    .neg_o(neg_u), .ovf_o(ovf_u), .valid_o(val_u), .busy_o(busy_u)
  );

  // A conversion completes when busy falls; outputs must not move while busy.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy_s) begin
        if ({dig_s, neg_s, ovf_s, val_s} !== hold_s) glitch_s = 1'b1;
      end else if (prev_s) begin
        n_tests++;
        if (q_s.size() == 0) begin
          n_fail++;
          $display("FAIL signed_unexpected actual digits=%h neg=%b ovf=%b", dig_s, neg_s, ovf_s);
        end else begin
          e_s = q_s.pop_front();
          if ({dig_s, neg_s, ovf_s, val_s} !== {e_s.d, e_s.n, e_s.o, 1'b1}) begin
            n_fail++;
            $display("FAIL signed_result actual digits=%h neg=%b ovf=%b valid=%b required digits=%h neg=%b ovf=%b valid=1",
                     dig_s, neg_s, ovf_s, val_s, e_s.d, e_s.n, e_s.o);
          end
        end
        n_tests++;
        if (glitch_s) begin
          n_fail++;
          $display("FAIL signed_stable actual glitch=1 required glitch=0");
        end
        hold_s   = {dig_s, neg_s, ovf_s, val_s};
        glitch_s = 1'b0;
        done_s++;
      end
      prev_s = busy_s;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (busy_u) begin
        if ({dig_u, neg_u, ovf_u, val_u} !== hold_u) glitch_u = 1'b1;
      end else if (prev_u) begin
        n_tests++;
        if (q_u.size() == 0) begin
          n_fail++;
          $display("FAIL unsigned_unexpected actual digits=%h neg=%b ovf=%b", dig_u, neg_u, ovf_u);
        end else begin
          e_u = q_u.pop_front();
          if ({dig_u, neg_u, ovf_u, val_u} !== {e_u.d, e_u.n, e_u.o, 1'b1}) begin
            n_fail++;
            $display("FAIL unsigned_result actual digits=%h neg=%b ovf=%b valid=%b required digits=%h neg=%b ovf=%b valid=1",
                     dig_u, neg_u, ovf_u, val_u, e_u.d, e_u.n, e_u.o);
          end
        end
        n_tests++;
        if (glitch_u) begin
          n_fail++;
          $display("FAIL unsigned_stable actual glitch=1 required glitch=0");
        end
        hold_u   = {dig_u, neg_u, ovf_u, val_u};
        glitch_u = 1'b0;
        done_u++;
      end
      prev_u = busy_u;
    end
  end

  task automatic wait_s(input int target, input string name);
    int k = 0;
    while (done_s < target && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (done_s < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout actual done=%0d required done=%0d", name, done_s, target);
    end
    @(negedge clk);
  endtask

  task automatic wait_u(input int target, input string name);
    int k = 0;
    while (done_u < target && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (done_u < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout actual done=%0d required done=%0d", name, done_u, target);
    end
    @(negedge clk);
  endtask

  task automatic wait_busy_s(input string name);
    int k = 0;
    while (!busy_s && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!busy_s) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s no_start actual busy=0 required busy=1", name);
    end
  endtask

  task automatic conv_s(input logic [31:0] v, input logic [15:0] d, input logic n, input logic o,
                        input string name);
    int target;
    target = done_s + 1;
    data_s = v;
    q_s.push_back(exp_t'({d, n, o}));
    wait_s(target, name);
  endtask

  task automatic conv_u(input logic [31:0] v, input logic [15:0] d, input logic n, input logic o,
                        input string name);
    int target;
    target = done_u + 1;
    data_u = v;
    q_u.push_back(exp_t'({d, n, o}));
    wait_u(target, name);
  endtask

  initial begin
    int bc;
    int target;
    rst    = 1'b1;
    data_s = 32'd0;
    data_u = 32'd0;
    repeat (3) @(negedge clk);

    n_tests++;
    if ({dig_s, neg_s, ovf_s, val_s, busy_s} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_state actual=%h required=00000", {dig_s, neg_s, ovf_s, val_s, busy_s});
    end

    // First conversion is forced by valid_o=0; 32 shift cycles plus DONE keep busy high.
    q_s.push_back(exp_t'({16'h0000, 1'b0, 1'b0}));
    q_u.push_back(exp_t'({16'h0000, 1'b0, 1'b0}));
    rst = 1'b0;
    bc  = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy_s) bc++;
    end
    n_tests++;
    if (bc != 33 || done_s != 1 || done_u != 1) begin
      n_fail++;
      $display("FAIL first_conversion actual busy_cycles=%0d done_s=%0d done_u=%0d required 33 1 1",
               bc, done_s, done_u);
    end

    bc = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_s) bc++;
    end
    n_tests++;
    if (bc != 0) begin
      n_fail++;
      $display("FAIL no_retrigger actual busy_cycles=%0d required 0", bc);
    end

    conv_s(32'd1234,       16'h1234, 1'b0, 1'b0, "pos_1234");
    conv_s(32'hFFFFFFD6,   16'hA042, 1'b1, 1'b0, "neg_42");
    conv_s(32'd9999,       16'h9999, 1'b0, 1'b0, "pos_max");
    conv_s(32'd10000,      16'hFFFF, 1'b0, 1'b1, "pos_ovf");
    conv_s(-32'sd999,      16'hA999, 1'b1, 1'b0, "neg_max");
    conv_s(-32'sd1000,     16'hFFFF, 1'b1, 1'b1, "neg_ovf");
    conv_s(32'h80000000,   16'hFFFF, 1'b1, 1'b1, "int_min");

    conv_u(32'hFFFFFFFF,   16'hFFFF, 1'b0, 1'b1, "u_all_ones");
    conv_u(32'hFFFFFFD6,   16'hFFFF, 1'b0, 1'b1, "u_big");
    conv_u(32'd42,         16'h0042, 1'b0, 1'b0, "u_42");

    // Input change mid-conversion: old value finishes, new one follows automatically.
    target = done_s + 2;
    data_s = 32'd5;
    q_s.push_back(exp_t'({16'h0005, 1'b0, 1'b0}));
    wait_busy_s("change_start");
    repeat (10) @(negedge clk);
    data_s = 32'd77;
    q_s.push_back(exp_t'({16'h0077, 1'b0, 1'b0}));
    wait_s(target, "change_mid");

    // Asynchronous reset in the middle of a shift sequence.
    data_s = 32'hFFFFFFF9;
    q_s.push_back(exp_t'({16'hA007, 1'b1, 1'b0}));
    wait_busy_s("rst_mid_start");
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({dig_s, neg_s, ovf_s, val_s, busy_s} !== 20'd0) begin
      n_fail++;
      $display("FAIL async_reset actual=%h required=00000", {dig_s, neg_s, ovf_s, val_s, busy_s});
    end
    q_s.delete();
    q_u.delete();
    prev_s   = 1'b0;
    prev_u   = 1'b0;
    glitch_s = 1'b0;
    glitch_u = 1'b0;
    hold_s   = '0;
    hold_u   = '0;
    #5;
    target = done_u + 1;
    q_s.push_back(exp_t'({16'hA007, 1'b1, 1'b0}));
    q_u.push_back(exp_t'({16'h0042, 1'b0, 1'b0}));
    rst = 1'b0;
    wait_s(done_s + 1, "rst_restart_s");
    wait_u(target, "rst_restart_u");

    n_tests++;
    if (q_s.size() != 0 || q_u.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expect actual q_s=%0d q_u=%0d required 0 0", q_s.size(), q_u.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
